// File: rtl/lab6_avm_pkg.sv
// Shared FSM state type and counter widths for the lab6 Avalon-MM command master.
package lab6_avm_pkg;

  typedef enum logic [1:0] {
    AVM_IDLE,
    AVM_ACCESS,
    AVM_RLAT,
    AVM_RESP
  } avm_state_t;

  // Stall counter must reach a TIMEOUT of up to 65535; read latency is at most 7.
  localparam int STALL_CNT_W = 16;
  localparam int LAT_CNT_W   = 3;

endpackage

// File: rtl/lab6_avm_cmd_master.sv
// Turns a valid/ready command stream into single-beat Avalon-MM PIO transfers,
// returning exactly one response (write ack, read data or timeout) per command.
module lab6_avm_cmd_master
  import lab6_avm_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  localparam logic [STALL_CNT_W-1:0] STALL_LIMIT = STALL_CNT_W'(TIMEOUT);
  localparam logic [LAT_CNT_W-1:0]   LAT_LOAD    =
    (READ_LATENCY > 0) ? LAT_CNT_W'(READ_LATENCY - 1) : '0;

  avm_state_t             state;
  avm_state_t             state_next;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [LAT_CNT_W-1:0]   lat_cnt;
  logic                   accept;
  logic                   done;
  logic                   abort;
  logic                   capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= AVM_IDLE;
    else       state <= state_next;
  end

  // A transfer in ACCESS is a write exactly when the registered write strobe is low.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    capture    = 1'b0;
    case (state)
      AVM_IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = AVM_ACCESS;
        end
      end
      AVM_ACCESS: begin
        if (!avm_waitrequest) begin
          done = 1'b1;
          if (!avm_write_n) begin
            state_next = AVM_RESP;
          end else if (READ_LATENCY == 0) begin
            capture    = 1'b1;
            state_next = AVM_RESP;
          end else begin
            state_next = AVM_RLAT;
          end
        end else if (stall_cnt == STALL_LIMIT) begin
          abort      = 1'b1;
          state_next = AVM_RESP;
        end
      end
      AVM_RLAT: begin
        if (lat_cnt == '0) begin
          capture    = 1'b1;
          state_next = AVM_RESP;
        end
      end
      AVM_RESP: state_next = AVM_IDLE;
      default:  state_next = AVM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_error      <= 1'b0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_read_n     <= 1'b1;
      avm_writedata  <= '0;
      stall_cnt      <= '0;
      lat_cnt        <= '0;
    end else begin
      cmd_ready <= (state_next == AVM_IDLE);
      rsp_valid <= (state_next == AVM_RESP);

      if (accept) begin
        avm_address    <= cmd_addr;
        avm_writedata  <= cmd_wdata;
        avm_chipselect <= 1'b1;
        avm_write_n    <= ~cmd_write;
        avm_read_n     <= cmd_write;
        stall_cnt      <= '0;
      end

      if (done || abort) begin
        avm_chipselect <= 1'b0;
        avm_write_n    <= 1'b1;
        avm_read_n     <= 1'b1;
      end

      if (state == AVM_ACCESS && avm_waitrequest && stall_cnt != STALL_LIMIT)
        stall_cnt <= stall_cnt + 1'b1;

      if (done && avm_write_n)
        lat_cnt <= LAT_LOAD;
      else if (state == AVM_RLAT && lat_cnt != '0)
        lat_cnt <= lat_cnt - 1'b1;

      // Response payload is only touched on the way into RESP, so it holds afterwards.
      if (done && !avm_write_n) begin
        rsp_rdata <= '0;
        rsp_error <= 1'b0;
      end
      if (capture) begin
        rsp_rdata <= avm_readdata;
        rsp_error <= 1'b0;
      end
      if (abort) begin
        rsp_rdata <= '0;
        rsp_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lab6_avm_cmd_master.sv
// Bench for lab6_avm_cmd_master: two instances (read latency 0 and 2) on PIO-style
// slave models, checked against a command-level model of latency and response data.
module tb_lab6_avm_cmd_master;

  localparam int TMO  = 8;
  localparam int LAT0 = 0;
  localparam int LAT1 = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        cmd_valid       [2];
  logic        cmd_ready       [2];
  logic        cmd_write       [2];
  logic [1:0]  cmd_addr        [2];
  logic [31:0] cmd_wdata       [2];
  logic        rsp_valid       [2];
  logic [31:0] rsp_rdata       [2];
  logic        rsp_error       [2];
  logic [1:0]  avm_address     [2];
  logic        avm_chipselect  [2];
  logic        avm_write_n     [2];
  logic        avm_read_n      [2];
  logic [31:0] avm_writedata   [2];
  logic [31:0] avm_readdata    [2];
  logic        avm_waitrequest [2];

  logic [31:0] smem      [2][4];
  logic [31:0] model_mem [2][4];
  int          stall_cfg [2];
  int          stall_cnt [2];
  logic [31:0] noise;
  logic [31:0] pipe0;
  logic [31:0] pipe1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lab6_avm_cmd_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(LAT0), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
    .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]),
    .avm_address(avm_address[0]), .avm_chipselect(avm_chipselect[0]),
    .avm_write_n(avm_write_n[0]), .avm_read_n(avm_read_n[0]),
    .avm_writedata(avm_writedata[0]), .avm_readdata(avm_readdata[0]),
    .avm_waitrequest(avm_waitrequest[0])
  );

  lab6_avm_cmd_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(LAT1), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
    .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]),
    .avm_address(avm_address[1]), .avm_chipselect(avm_chipselect[1]),
    .avm_write_n(avm_write_n[1]), .avm_read_n(avm_read_n[1]),
    .avm_writedata(avm_writedata[1]), .avm_readdata(avm_readdata[1]),
    .avm_waitrequest(avm_waitrequest[1])
  );

  // Slave models: stall for stall_cfg cycles per access; instance 1 returns data two cycles late.
  always_comb begin
    for (int u = 0; u < 2; u++)
      avm_waitrequest[u] = avm_chipselect[u] && (stall_cnt[u] < stall_cfg[u]);
    avm_readdata[0] = (avm_chipselect[0] && !avm_read_n[0]) ? smem[0][avm_address[0]] : noise;
    avm_readdata[1] = pipe1;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int u = 0; u < 2; u++) begin
        stall_cnt[u] <= 0;
        for (int a = 0; a < 4; a++) smem[u][a] <= 32'h0;
      end
      noise <= 32'h0BAD_0000;
      pipe0 <= 32'h0;
      pipe1 <= 32'h0;
    end else begin
      noise <= $urandom;
      for (int u = 0; u < 2; u++) begin
        if (avm_chipselect[u] && avm_waitrequest[u]) stall_cnt[u] <= stall_cnt[u] + 1;
        else                                         stall_cnt[u] <= 0;
        if (avm_chipselect[u] && !avm_waitrequest[u] && !avm_write_n[u])
          smem[u][avm_address[u]] <= avm_writedata[u];
      end
      pipe0 <= (avm_chipselect[1] && !avm_waitrequest[1] && !avm_read_n[1])
               ? smem[1][avm_address[1]] : $urandom;
      pipe1 <= pipe0;
    end
  end

  task automatic clear_model();
    for (int u = 0; u < 2; u++)
      for (int a = 0; a < 4; a++) model_mem[u][a] = 32'h0;
  endtask

  // One command end to end: expected latency is 2 + stalls (+ read latency), or TMO+2 on timeout.
  task automatic run_cmd(input int u, input logic wr, input logic [1:0] addr,
                         input logic [31:0] wdata, input int stall, input string tag);
    int          exp_cyc;
    int          acc_last;
    int          cyc;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic        ok;
    bit          seen;
    exp_err = (stall > TMO);
    if (exp_err) begin
      exp_cyc  = TMO + 2;
      acc_last = TMO + 1;
      exp_rd   = 32'h0;
    end else begin
      exp_cyc  = 2 + stall + (wr ? 0 : ((u == 0) ? LAT0 : LAT1));
      acc_last = stall + 1;
      exp_rd   = wr ? 32'h0 : model_mem[u][addr];
      if (wr) model_mem[u][addr] = wdata;
    end
    stall_cfg[u] = stall;
    @(negedge clk);
    cyc = 0;
    while (cmd_ready[u] !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (cmd_ready[u] !== 1'b1) begin
      total++; bad++;
      $display("[TB] FAIL %s ready: cmd_ready=%b want=1", tag, cmd_ready[u]);
      return;
    end
    cmd_write[u] = wr;
    cmd_addr[u]  = addr;
    cmd_wdata[u] = wdata;
    cmd_valid[u] = 1'b1;
    @(negedge clk);
    cmd_valid[u] = 1'b0;
    cmd_addr[u]  = 2'($urandom);
    cmd_wdata[u] = $urandom;
    cyc  = 1;
    seen = 0;
    while (!seen && cyc <= exp_cyc + 3) begin
      if (rsp_valid[u] === 1'b1) begin
        seen = 1;
        total++;
        if (cyc != exp_cyc) begin
          bad++; $display("[TB] FAIL %s latency: got=%0d want=%0d", tag, cyc, exp_cyc);
        end
        total++;
        if (rsp_error[u] !== exp_err) begin
          bad++; $display("[TB] FAIL %s rsp_error: got=%b want=%b", tag, rsp_error[u], exp_err);
        end
        total++;
        if (rsp_rdata[u] !== exp_rd) begin
          bad++; $display("[TB] FAIL %s rsp_rdata: got=%h want=%h", tag, rsp_rdata[u], exp_rd);
        end
        if (wr && !exp_err) begin
          total++;
          if (smem[u][addr] !== wdata) begin
            bad++; $display("[TB] FAIL %s slave reg: got=%h want=%h", tag, smem[u][addr], wdata);
          end
        end
      end else begin
        if (cyc <= acc_last)
          ok = avm_chipselect[u] === 1'b1 && avm_write_n[u] === ~wr && avm_read_n[u] === wr &&
               avm_address[u] === addr && (!wr || avm_writedata[u] === wdata);
        else
          ok = avm_chipselect[u] === 1'b0 && avm_write_n[u] === 1'b1 && avm_read_n[u] === 1'b1;
        total++;
        if (!ok) begin
          bad++;
          $display("[TB] FAIL %s bus cyc%0d: cs=%b wn=%b rn=%b a=%h d=%h want active=%0d",
                   tag, cyc, avm_chipselect[u], avm_write_n[u], avm_read_n[u],
                   avm_address[u], avm_writedata[u], (cyc <= acc_last));
        end
        total++;
        if (cmd_ready[u] !== 1'b0) begin
          bad++; $display("[TB] FAIL %s busy ready cyc%0d: got=%b want=0", tag, cyc, cmd_ready[u]);
        end
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL %s no response: got none want cycle %0d", tag, exp_cyc);
    end else if (rsp_valid[u] !== 1'b0 || cmd_ready[u] !== 1'b1 ||
                 rsp_rdata[u] !== exp_rd || rsp_error[u] !== exp_err) begin
      bad++;
      $display("[TB] FAIL %s after resp: valid=%b ready=%b rd=%h err=%b want 0 1 %h %b",
               tag, rsp_valid[u], cmd_ready[u], rsp_rdata[u], rsp_error[u], exp_rd, exp_err);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input bit check_ready);
    for (int u = 0; u < 2; u++) begin
      total++;
      if (avm_chipselect[u] !== 1'b0 || avm_write_n[u] !== 1'b1 || avm_read_n[u] !== 1'b1 ||
          avm_address[u] !== 2'h0 || avm_writedata[u] !== 32'h0 || rsp_valid[u] !== 1'b0 ||
          rsp_rdata[u] !== 32'h0 || rsp_error[u] !== 1'b0 || (check_ready && cmd_ready[u] !== 1'b1)) begin
        bad++;
        $display("[TB] FAIL %s u%0d: cs=%b wn=%b rn=%b a=%h d=%h rv=%b rd=%h err=%b rdy=%b want reset values",
                 tag, u, avm_chipselect[u], avm_write_n[u], avm_read_n[u], avm_address[u],
                 avm_writedata[u], rsp_valid[u], rsp_rdata[u], rsp_error[u], cmd_ready[u]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_hold", 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_release", 1'b1);
  endtask

  task automatic test_pio_write_read();
    run_cmd(0, 1'b1, 2'd0, 32'h0000_1234, 0, "pio_write");
    run_cmd(0, 1'b0, 2'd0, 32'h0, 0, "pio_read0");
    run_cmd(0, 1'b0, 2'd1, 32'h0, 0, "pio_read1");
  endtask

  task automatic test_wait_states();
    run_cmd(0, 1'b1, 2'd2, 32'h0000_A5A5, 3, "wait_write");
    run_cmd(0, 1'b0, 2'd2, 32'h0, 2, "wait_read");
    run_cmd(0, 1'b1, 2'd3, 32'h1357_9BDF, TMO, "wait_at_limit");
  endtask

  task automatic test_read_latency();
    run_cmd(1, 1'b1, 2'd3, 32'hDEAD_BEEF, 0, "lat_write");
    run_cmd(1, 1'b0, 2'd3, 32'h0, 0, "lat_read");
    run_cmd(1, 1'b0, 2'd3, 32'h0, 2, "lat_read_stall");
  endtask

  task automatic test_timeout();
    run_cmd(0, 1'b1, 2'd1, 32'hCAFE_F00D, 1000, "tmo_stuck");
    run_cmd(0, 1'b0, 2'd0, 32'h0, 0, "tmo_next");
    run_cmd(1, 1'b0, 2'd3, 32'h0, TMO + 1, "tmo_read_boundary");
    run_cmd(1, 1'b0, 2'd3, 32'h0, 1, "tmo_read_next");
  endtask

  // Commands held valid continuously must be accepted exactly three cycles apart.
  task automatic test_back_to_back();
    logic        wrs   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  addrs [4] = '{2'd1, 2'd1, 2'd2, 2'd2};
    logic [31:0] datas [4];
    logic [31:0] exp_q [$];
    logic [31:0] e;
    int          n_acc = 0;
    int          n_rsp = 0;
    int          cyc = 0;
    int          last_acc = -1;
    bit          load = 0;
    datas[0] = $urandom; datas[1] = 32'h0; datas[2] = $urandom; datas[3] = 32'h0;
    stall_cfg[0] = 0;
    @(negedge clk);
    cmd_write[0] = wrs[0]; cmd_addr[0] = addrs[0]; cmd_wdata[0] = datas[0];
    cmd_valid[0] = 1'b1;
    while (n_rsp < 4 && cyc < 60) begin
      if (load) begin
        load = 0;
        if (n_acc < 4) begin
          cmd_write[0] = wrs[n_acc]; cmd_addr[0] = addrs[n_acc]; cmd_wdata[0] = datas[n_acc];
        end else begin
          cmd_valid[0] = 1'b0;
        end
      end
      if (rsp_valid[0] === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        total++;
        if (rsp_rdata[0] !== e || rsp_error[0] !== 1'b0) begin
          bad++; $display("[TB] FAIL b2b rsp%0d: rd=%h err=%b want %h 0", n_rsp, rsp_rdata[0], rsp_error[0], e);
        end
        n_rsp++;
      end
      if (cmd_valid[0] === 1'b1 && cmd_ready[0] === 1'b1) begin
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc != 3) begin
            bad++; $display("[TB] FAIL b2b period: got=%0d want=3", cyc - last_acc);
          end
        end
        last_acc = cyc;
        exp_q.push_back(wrs[n_acc] ? 32'h0 : model_mem[0][addrs[n_acc]]);
        if (wrs[n_acc]) model_mem[0][addrs[n_acc]] = datas[n_acc];
        n_acc++;
        load = 1;
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid[0] = 1'b0;
    total++;
    if (n_rsp != 4) begin
      bad++; $display("[TB] FAIL b2b responses: got=%0d want=4", n_rsp);
    end
  endtask

  task automatic test_reset_mid_transfer();
    stall_cfg[0] = 1000;
    @(negedge clk);
    cmd_write[0] = 1'b1; cmd_addr[0] = 2'd3; cmd_wdata[0] = 32'h7777_8888;
    cmd_valid[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (avm_chipselect[0] !== 1'b1) begin
      bad++; $display("[TB] FAIL rst_mid stalled: cs=%b want=1", avm_chipselect[0]);
    end
    #2 reset = 1'b1;
    clear_model();
    #1 check_idle_outputs("rst_mid_async", 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle_outputs("rst_mid_after", 1'b1);
    end
    run_cmd(0, 1'b0, 2'd3, 32'h0, 0, "rst_mid_read");
  endtask

  task automatic test_random();
    int idx;
    int stall;
    for (int n = 0; n < 30; n++) begin
      idx   = $urandom_range(0, 6);
      stall = (idx <= 3) ? idx : (idx == 4) ? TMO : (idx == 5) ? TMO + 1 : 1000;
      run_cmd($urandom_range(0, 1), 1'($urandom), 2'($urandom), $urandom, stall, "random");
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      cmd_valid[u] = 1'b0; cmd_write[u] = 1'b0; cmd_addr[u] = 2'd0; cmd_wdata[u] = 32'h0;
      stall_cfg[u] = 0;
    end
    clear_model();
    test_reset();
    test_pio_write_read();
    test_wait_states();
    test_read_latency();
    test_timeout();
    test_back_to_back();
    test_reset_mid_transfer();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
